// File: rtl/btn_debounce_pulse.sv
// Debounces a raw push-button into a clean level and a one-cycle step pulse.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses while the button stays pressed.
module btn_debounce_pulse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       en,
    output logic       pulse,
    output logic       level,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESS_W = 2'b01,
        HELD    = 2'b10,
        REL_W   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;
    state_t                 state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic                   level_nx;
    logic                   pulse_nx;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // rpt_run is set once the first repeat has fired, switching to the shorter period
    logic [CNT_W-1:0] rcnt, rcnt_nx;
    logic             rpt_run, rpt_run_nx;
`else
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_ignored
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rcnt    <= '0;
            rpt_run <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
            pulse <= pulse_nx;
`ifdef AUTO_REPEAT_EN
            rcnt    <= rcnt_nx;
            rpt_run <= rpt_run_nx;
`endif
        end
    end

    // A glitch back to the previous level during either wait state simply abandons the wait.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        pulse_nx = 1'b0;
`ifdef AUTO_REPEAT_EN
        rcnt_nx    = rcnt;
        rpt_run_nx = rpt_run;
`endif
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_nx = PRESS_W;
                    cnt_nx   = '0;
                end
            end
            PRESS_W: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nx = HELD;
                    level_nx = 1'b1;
                    pulse_nx = en;
`ifdef AUTO_REPEAT_EN
                    rcnt_nx    = '0;
                    rpt_run_nx = 1'b0;
`endif
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nx = REL_W;
                    cnt_nx   = '0;
                end
`ifdef AUTO_REPEAT_EN
                else if (rcnt == (rpt_run ? RPT_PERIOD_LAST : RPT_FIRST_LAST)) begin
                    pulse_nx   = en;
                    rcnt_nx    = '0;
                    rpt_run_nx = 1'b1;
                end else begin
                    rcnt_nx = rcnt + 1'b1;
                end
`endif
            end
            REL_W: begin
                if (btn_s) begin
                    state_nx = HELD;
                end else if (cnt == DB_LAST) begin
                    state_nx = IDLE;
                    level_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign state_o = state;

endmodule
